// File: rtl/contador_bcd.sv
// Tick-driven 4-digit BCD up/down counter with start/stop/clear control.
// tick_in is synchronised and edge-detected; every output is registered.
module contador_bcd #(
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up_down,
  output logic [15:0] bcd,
  output logic        running,
  output logic        done,
  output logic        wrap_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   tick_prev;
  logic                   tick_rise;
  logic [16:0]            step;

  // One BCD step; bit 16 is the carry/borrow out of the top digit.
  function automatic logic [16:0] bcd_step(input logic [15:0] value, input logic up);
    logic [15:0] result;
    logic        carry;
    logic [3:0]  digit;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit = value[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            digit = 4'd0;
          end else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            digit = 4'd9;
          end else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      result[4*i +: 4] = digit;
    end
    return {carry, result};
  endfunction

  // Reset to ones so a tick_in held high through reset never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= '1;
      tick_prev <= 1'b1;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], tick_in};
      tick_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick_rise = sync[SYNC_STAGES-1] & ~tick_prev;
  assign step      = bcd_step(bcd, up_down);

  // Control FSM with count and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bcd        <= 16'h0000;
      running    <= 1'b0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        bcd     <= 16'h0000;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            // stop outranks start, so asserting both keeps the count parked
            if (!stop && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick_rise) begin
              if (step[16] && !WRAP) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end else begin
                bcd        <= step[15:0];
                wrap_pulse <= step[16];
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_bcd.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared every cycle against an integer-count reference model.
module tb_contador_bcd;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        up_down = 1'b1;
  logic [15:0] bcd1, bcd0;
  logic        running1, running0, done1, done0, wp1, wp0;

  int tests = 0;
  int fails = 0;
  int wpc1 = 0;
  int wpc0 = 0;

  contador_bcd #(.SYNC_STAGES(S), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .up_down(up_down), .bcd(bcd1), .running(running1),
    .done(done1), .wrap_pulse(wp1)
  );

  contador_bcd #(.SYNC_STAGES(S), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .up_down(up_down), .bcd(bcd0), .running(running0),
    .done(done0), .wrap_pulse(wp0)
  );

  always #5 clk = ~clk;

  // Reference model: count is a plain integer 0..9999; st 0=idle 1=run 2=pause 3=done.
  typedef struct {
    int cnt;
    int st;
    bit wp;
  } mdl_t;

  mdl_t     m1, m0;
  logic [S:0] hist;   // hist[j] = tick_in sampled j+1 edges ago
  logic       m_rise;

  assign m_rise = hist[S-1] & ~hist[S];

  function automatic mdl_t mstep(input mdl_t cur, input bit wrap_en, input bit rise);
    mdl_t nxt;
    nxt    = cur;
    nxt.wp = 1'b0;
    if (clear) begin
      nxt.cnt = 0;
      nxt.st  = 0;
    end else if (cur.st == 0 || cur.st == 2) begin
      if (!stop && start) nxt.st = 1;
    end else if (cur.st == 1) begin
      if (stop) begin
        nxt.st = 2;
      end else if (rise) begin
        if ((up_down && cur.cnt == 9999) || (!up_down && cur.cnt == 0)) begin
          if (wrap_en) begin
            nxt.cnt = up_down ? 0 : 9999;
            nxt.wp  = 1'b1;
          end else begin
            nxt.st = 3;
          end
        end else begin
          nxt.cnt = up_down ? cur.cnt + 1 : cur.cnt - 1;
        end
      end
    end
    return nxt;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '1;
      m1   <= '{cnt: 0, st: 0, wp: 1'b0};
      m0   <= '{cnt: 0, st: 0, wp: 1'b0};
    end else begin
      hist <= {hist[S-1:0], tick_in};
      m1   <= mstep(m1, 1'b1, m_rise);
      m0   <= mstep(m0, 1'b0, m_rise);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("wrap.bcd", {16'h0, bcd1}, {16'h0, to_bcd(m1.cnt)});
      check("wrap.running", {31'h0, running1}, {31'h0, m1.st == 1});
      check("wrap.done", {31'h0, done1}, {31'h0, m1.st == 3});
      check("wrap.wrap_pulse", {31'h0, wp1}, {31'h0, m1.wp});
      check("sat.bcd", {16'h0, bcd0}, {16'h0, to_bcd(m0.cnt)});
      check("sat.running", {31'h0, running0}, {31'h0, m0.st == 1});
      check("sat.done", {31'h0, done0}, {31'h0, m0.st == 3});
      check("sat.wrap_pulse", {31'h0, wp0}, {31'h0, m0.wp});
    end
  end

  always @(negedge clk) begin
    if (wp1) wpc1 <= wpc1 + 1;
    if (wp0) wpc0 <= wpc0 + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic tick_once();
    @(negedge clk) tick_in = 1'b1;
    cyc(2);
    tick_in = 1'b0;
    cyc(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  initial begin
    #1 reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("reset.bcd", {16'h0, bcd1}, 32'h0000);
    check("reset.running", {31'h0, running1}, 32'h0);

    // Basic count: 12 up ticks
    up_down = 1'b1;
    pulse_start();
    ticks(12);
    cyc(2);
    check("basic.bcd", {16'h0, bcd1}, 32'h0012);
    check("basic.running", {31'h0, running1}, 32'h1);
    check("basic.sat_bcd", {16'h0, bcd0}, 32'h0012);

    // Latency: count moves two edges after tick_in rises, once per rising edge
    @(negedge clk) tick_in = 1'b1;
    cyc(1);
    check("lat.k", {16'h0, bcd1}, 32'h0012);
    cyc(1);
    check("lat.k1", {16'h0, bcd1}, 32'h0012);
    cyc(1);
    check("lat.k2", {16'h0, bcd1}, 32'h0013);
    cyc(17);
    tick_in = 1'b0;
    cyc(4);
    check("lat.held_high", {16'h0, bcd1}, 32'h0013);

    // Wrap / saturate at zero going down, then up again
    pulse_clear();
    pulse_start();
    up_down = 1'b0;
    tick_once();
    check("wrap.down_bcd", {16'h0, bcd1}, 32'h9999);
    check("wrap.down_pulses", wpc1, 32'd1);
    check("sat.down_bcd", {16'h0, bcd0}, 32'h0000);
    check("sat.down_done", {31'h0, done0}, 32'h1);
    check("sat.down_running", {31'h0, running0}, 32'h0);
    pulse_start();
    cyc(1);
    check("sat.start_ignored", {31'h0, done0}, 32'h1);
    up_down = 1'b1;
    tick_once();
    check("wrap.up_bcd", {16'h0, bcd1}, 32'h0000);
    check("wrap.up_pulses", wpc1, 32'd2);
    check("sat.no_pulses", wpc0, 32'd0);
    pulse_clear();
    cyc(1);
    check("sat.clear_done", {31'h0, done0}, 32'h0);

    // Digit carry chain 0999 -> 1000
    pulse_start();
    ticks(999);
    check("carry.0999", {16'h0, bcd1}, 32'h0999);
    tick_once();
    check("carry.1000", {16'h0, bcd1}, 32'h1000);

    // stop in the same cycle as tick_rise: pause, count unchanged
    @(negedge clk) tick_in = 1'b1;
    cyc(2);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("stoptick.bcd", {16'h0, bcd1}, 32'h1000);
    check("stoptick.running", {31'h0, running1}, 32'h0);
    cyc(1);
    tick_in = 1'b0;
    cyc(2);
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("pause.start_stop", {31'h0, running1}, 32'h0);
    pulse_start();
    check("pause.resume", {31'h0, running1}, 32'h1);

    // clear together with a tick in RUN at 0042
    pulse_clear();
    pulse_start();
    ticks(42);
    check("cleartick.pre", {16'h0, bcd1}, 32'h0042);
    @(negedge clk) tick_in = 1'b1;
    cyc(2);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("cleartick.bcd", {16'h0, bcd1}, 32'h0000);
    check("cleartick.running", {31'h0, running1}, 32'h0);
    cyc(2);
    tick_in = 1'b0;
    cyc(2);

    // tick_in high across reset produces no count until it falls and rises
    @(negedge clk) begin tick_in = 1'b1; reset = 1'b1; end
    cyc(2);
    reset = 1'b0;
    pulse_start();
    cyc(6);
    check("rsthigh.bcd", {16'h0, bcd1}, 32'h0000);
    check("rsthigh.running", {31'h0, running1}, 32'h1);
    tick_in = 1'b0;
    cyc(2);
    tick_in = 1'b1;
    cyc(4);
    check("rsthigh.after_edge", {16'h0, bcd1}, 32'h0001);
    tick_in = 1'b0;
    cyc(2);

    // Asynchronous reset mid-RUN at 0057
    pulse_clear();
    pulse_start();
    ticks(57);
    check("asyncrst.pre", {16'h0, bcd1}, 32'h0057);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("asyncrst.bcd", {16'h0, bcd1}, 32'h0000);
    check("asyncrst.running", {31'h0, running1}, 32'h0);
    check("asyncrst.sat_bcd", {16'h0, bcd0}, 32'h0000);
    cyc(2);
    reset = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/contador_bcd.md
# contador_bcd

Tick-driven 4-digit BCD up/down counter with start/stop/clear control. It sits directly downstream of the clock divider: the divider's slow square-wave output drives `tick_in`, and this block advances the count once per rising edge of that signal. `tick_in` is synchronised and edge-detected inside the block. The packed BCD value feeds the display stage.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `tick_in` synchroniser; minimum 2.
- `WRAP`, 1: 1 = wrap 9999↔0000 and keep running; 0 = saturate at the limit and enter DONE.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_in`  in  1  slow clock from the divider; asynchronous to the logic, treated as data.
- `start`  in  1  level, sampled each `clk`; run request.
- `stop`  in  1  level, sampled each `clk`; pause request.
- `clear`  in  1  level, sampled each `clk`; zero the count and return to IDLE.
- `up_down`  in  1  count direction: 1 = up, 0 = down; sampled in the tick cycle.
- `bcd`  out  16  count as four BCD digits: {d3,d2,d1,d0}, d0 in [3:0].
- `running`  out  1  1 while in RUN.
- `done`  out  1  1 while in DONE; reachable only with WRAP=0.
- `wrap_pulse`  out  1  one-cycle pulse on each 9999→0000 or 0000→9999 transition.

## Operation
- **Synchroniser.** `tick_in` passes through a chain of `SYNC_STAGES` flops, then a previous-value flop.
  - `tick_rise` = last stage & ~previous, asserted for exactly one `clk` cycle per `tick_in` rising edge.
  - All synchroniser and previous flops reset to 1. A `tick_in` held high through reset therefore produces no tick; `tick_in` must first be seen low.
- **States:** IDLE, RUN, PAUSE, DONE. Priority per cycle: `clear` > `stop` > `start` > `tick_rise`.
- **`clear` (any state):** `bcd`←0x0000, state←IDLE, `wrap_pulse`←0. Any same-cycle tick is dropped.
- **IDLE:** count held.
  - `start` → RUN.
  - A tick in the same cycle as `start` is ignored, because the count only changes while already in RUN.
- **RUN:**
  - `stop` → PAUSE; a same-cycle tick is dropped.
  - Otherwise `tick_rise` updates the count by ±1 according to `up_down`.
- **PAUSE:** count held. `start` → RUN. `stop` has no effect.
- **DONE:** count held. `start` and `stop` are ignored; only `clear` exits (to IDLE).
- **BCD arithmetic** is per digit, each digit always 0–9.
  - Up: a digit at 9 becomes 0 and carries into the next digit.
  - Down: a digit at 0 becomes 9 and borrows from the next digit.
  - Carry out of d3 or borrow out of d3 marks a wrap event.
- **Wrap event, WRAP=1:** count wraps (9999→0000 or 0000→9999), `wrap_pulse`=1 for that one cycle, state stays RUN.
- **Wrap event, WRAP=0:** count stays at 9999 (up) or 0000 (down), state→DONE, `wrap_pulse` stays 0.
- **Direction change** between ticks is legal and needs no special handling.

## Timing
- **Reset values:** `bcd`=0x0000, `running`=0, `done`=0, `wrap_pulse`=0, state IDLE.
- **Outputs** are all registered, with no combinational path from inputs to outputs.
- **Control latency:** a control input sampled at edge k produces its new state and outputs after edge k.
- **Tick latency:** `tick_in` rising, stable before `clk` edge k, updates `bcd` at edge k+`SYNC_STAGES`; with the default, 2 edges after k.
  - One count step per `tick_in` rising edge, regardless of how long `tick_in` stays high.
- **Tick spacing:** consecutive `tick_rise` pulses are at least 2 `clk` cycles apart. The divider guarantees far more.
- **Asynchronous reset mid-count:** takes effect immediately. No tick is produced on release unless `tick_in` goes low and then high again.

## Test plan
- **Basic count:** reset, `start` pulse, `up_down`=1, 12 `tick_in` rising edges → `bcd`=0x0012, `running`=1, `wrap_pulse` never asserted.
- **Latency:** `tick_in` rises before edge k in RUN, default parameters → `bcd` changes at edge k+2, not at k+1. Holding `tick_in` high for 20 cycles → exactly one increment.
- **Wrap, WRAP=1:** RUN, `up_down`=0 from 0x0000, one tick → `bcd`=0x9999, `wrap_pulse`=1 for exactly one cycle. Then `up_down`=1, one tick → 0x0000, one more `wrap_pulse`. Also count 0x0999 up by one tick → 0x1000.
- **Saturate, WRAP=0:** RUN, down tick at 0x0000 → `bcd`=0x0000, `done`=1, `running`=0, `wrap_pulse`=0. `start` then ignored; `clear` → IDLE with `done`=0.
- **Same-cycle events:**
  - `stop` in the cycle where `tick_rise` fires → PAUSE, count unchanged.
  - `start`+`stop` together in PAUSE → stays PAUSE.
  - `clear`+tick in RUN at 0x0042 → 0x0000, IDLE.
- **Reset:** `tick_in` high while `reset` asserts and releases, then `start` → no count until `tick_in` falls and rises again. Asserting `reset` mid-RUN at 0x0057 → `bcd`=0x0000, `running`=0 immediately, without waiting for a `clk` edge.
